main_decoder: RTL and testbench

- Main control decoder for the single-cycle/pipelined RV32I CPU.
- Maps the 7-bit instruction opcode to datapath control signals: register write, ALU operand select, memory write, result mux select, branch, ALU-op class and jump.
- Outputs are registered, one cycle after the opcode, so the block sits at the decode/execute boundary.
- The ALU decoder consumes ALU_op; the PC logic consumes branch and jump.

---
 rtl/main_decoder.sv | 139 +++++++++++++
 tb/tb_main_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/main_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : main_decoder
//  Purpose  : RV32I main control decoder. Maps the opcode to registered
//             datapath control signals, one cycle after the opcode is sampled.
//  Revision : 1.0  initial release
// ============================================================================
module main_decoder (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    output logic       reg_write,
    output logic       ALU_select,
    output logic       mem_write,
    output logic [1:0] result_select,
    output logic       branch,
    output logic [1:0] ALU_op,
    output logic       jump,
    output logic       illegal
);

    localparam logic [6:0] c_OP_LW     = 7'b0000011;
    localparam logic [6:0] c_OP_SW     = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;

    localparam logic [1:0] c_RES_ALU = 2'b00;
    localparam logic [1:0] c_RES_MEM = 2'b01;
    localparam logic [1:0] c_RES_PC4 = 2'b10;
    localparam logic [1:0] c_RES_IMM = 2'b11;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    logic       w_reg_write;
    logic       w_alu_select;
    logic       w_mem_write;
    logic [1:0] w_result_select;
    logic       w_branch;
    logic [1:0] w_alu_op;
    logic       w_jump;
    logic       w_illegal;

    // Every field defaults to 0 so don't-care columns never carry X and an
    // unsupported opcode leaves only the illegal flag set.
    always_comb begin
        w_reg_write     = 1'b0;
        w_alu_select    = 1'b0;
        w_mem_write     = 1'b0;
        w_result_select = c_RES_ALU;
        w_branch        = 1'b0;
        w_alu_op        = c_ALUOP_ADD;
        w_jump          = 1'b0;
        w_illegal       = 1'b0;
        case (opcode)
            c_OP_LW: begin
                w_reg_write     = 1'b1;
                w_alu_select    = 1'b1;
                w_result_select = c_RES_MEM;
            end
            c_OP_SW: begin
                w_alu_select    = 1'b1;
                w_mem_write     = 1'b1;
            end
            c_OP_RTYPE: begin
                w_reg_write     = 1'b1;
                w_alu_op        = c_ALUOP_FUNCT;
            end
            c_OP_BRANCH: begin
                w_branch        = 1'b1;
                w_alu_op        = c_ALUOP_SUB;
            end
            c_OP_ITYPE: begin
                w_reg_write     = 1'b1;
                w_alu_select    = 1'b1;
                w_alu_op        = c_ALUOP_FUNCT;
            end
            c_OP_JAL: begin
                w_reg_write     = 1'b1;
                w_result_select = c_RES_PC4;
                w_jump          = 1'b1;
            end
            c_OP_LUI: begin
                w_reg_write     = 1'b1;
                w_alu_select    = 1'b1;
                w_result_select = c_RES_IMM;
            end
            default: begin
                w_illegal       = 1'b1;
            end
        endcase
    end

    logic       r_reg_write;
    logic       r_alu_select;
    logic       r_mem_write;
    logic [1:0] r_result_select;
    logic       r_branch;
    logic [1:0] r_alu_op;
    logic       r_jump;
    logic       r_illegal;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_reg_write     <= 1'b0;
            r_alu_select    <= 1'b0;
            r_mem_write     <= 1'b0;
            r_result_select <= 2'b00;
            r_branch        <= 1'b0;
            r_alu_op        <= 2'b00;
            r_jump          <= 1'b0;
            r_illegal       <= 1'b0;
        end else begin
            r_reg_write     <= w_reg_write;
            r_alu_select    <= w_alu_select;
            r_mem_write     <= w_mem_write;
            r_result_select <= w_result_select;
            r_branch        <= w_branch;
            r_alu_op        <= w_alu_op;
            r_jump          <= w_jump;
            r_illegal       <= w_illegal;
        end
    end

    assign reg_write     = r_reg_write;
    assign ALU_select    = r_alu_select;
    assign mem_write     = r_mem_write;
    assign result_select = r_result_select;
    assign branch        = r_branch;
    assign ALU_op        = r_alu_op;
    assign jump          = r_jump;
    assign illegal       = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_main_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_main_decoder
//  Purpose  : Directed self-checking bench for main_decoder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_main_decoder;

    logic       clock;
    logic       reset;
    logic [6:0] opcode;
    logic       reg_write;
    logic       ALU_select;
    logic       mem_write;
    logic [1:0] result_select;
    logic       branch;
    logic [1:0] ALU_op;
    logic       jump;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    // Row layout: reg_write, ALU_select, mem_write, result_select, branch, ALU_op, jump, illegal
    localparam logic [9:0] c_ROW_ZERO = 10'b0_0_0_00_0_00_0_0;
    localparam logic [9:0] c_ROW_LW   = 10'b1_1_0_01_0_00_0_0;
    localparam logic [9:0] c_ROW_SW   = 10'b0_1_1_00_0_00_0_0;
    localparam logic [9:0] c_ROW_R    = 10'b1_0_0_00_0_10_0_0;
    localparam logic [9:0] c_ROW_BEQ  = 10'b0_0_0_00_1_01_0_0;
    localparam logic [9:0] c_ROW_I    = 10'b1_1_0_00_0_10_0_0;
    localparam logic [9:0] c_ROW_JAL  = 10'b1_0_0_10_0_00_1_0;
    localparam logic [9:0] c_ROW_LUI  = 10'b1_1_0_11_0_00_0_0;
    localparam logic [9:0] c_ROW_ILL  = 10'b0_0_0_00_0_00_0_1;

    main_decoder dut (
        .clock         (clock),
        .reset         (reset),
        .opcode        (opcode),
        .reg_write     (reg_write),
        .ALU_select    (ALU_select),
        .mem_write     (mem_write),
        .result_select (result_select),
        .branch        (branch),
        .ALU_op        (ALU_op),
        .jump          (jump),
        .illegal       (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [9:0] expected_row(input logic [6:0] op);
        case (op)
            7'b0000011: return c_ROW_LW;
            7'b0100011: return c_ROW_SW;
            7'b0110011: return c_ROW_R;
            7'b1100011: return c_ROW_BEQ;
            7'b0010011: return c_ROW_I;
            7'b1101111: return c_ROW_JAL;
            7'b0110111: return c_ROW_LUI;
            default:    return c_ROW_ILL;
        endcase
    endfunction

    function automatic logic [9:0] observed();
        return {reg_write, ALU_select, mem_write, result_select, branch, ALU_op, jump, illegal};
    endfunction

    task automatic check(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply an opcode, wait for the sampling edge, then sample 1 time unit later.
    task automatic step(input logic [6:0] op);
        opcode = op;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int legal_count;
        logic [6:0] sweep [9];
        sweep = '{7'b0000000, 7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011,
                  7'b0010011, 7'b1101111, 7'b0110111, 7'b1111111};

        reset  = 1'b1;
        opcode = 7'b0000011;
        @(negedge clock);

        // Reset holds everything at zero even with a legal opcode present
        step(7'b0000011);
        check("reset_edge1", c_ROW_ZERO);
        step(7'b0000011);
        check("reset_edge2", c_ROW_ZERO);
        reset = 1'b0;
        step(7'b0000011);
        check("post_reset_lw", c_ROW_LW);

        for (int i = 0; i < 9; i++) begin
            step(sweep[i]);
            check($sformatf("sweep_%b", sweep[i]), expected_row(sweep[i]));
        end
        step(7'b0000000);
        check("sweep_zero_op", c_ROW_ILL);
        step(7'b0000001);
        check("low_bits_exact_0000001", c_ROW_ILL);

        // Opcode change mid-cycle must not reach the outputs before the edge
        step(7'b0110011);
        check("latency_rtype", c_ROW_R);
        #3;
        opcode = 7'b0100011;
        #1;
        check("latency_hold_midcycle", c_ROW_R);
        @(posedge clock);
        #1;
        check("latency_sw_after_edge", c_ROW_SW);

        // Reset asserted during jal
        step(7'b0000011);
        check("stream_lw", c_ROW_LW);
        step(7'b0100011);
        check("stream_sw", c_ROW_SW);
        reset = 1'b1;
        step(7'b1101111);
        check("mid_reset_jal", c_ROW_ZERO);
        reset = 1'b0;
        step(7'b1101111);
        check("jal_after_reset", c_ROW_JAL);

        // Exhaustive scan of every opcode
        legal_count = 0;
        for (int op = 0; op < 128; op++) begin
            step(7'(op));
            check($sformatf("scan_%b", 7'(op)), expected_row(7'(op)));
            if (illegal === 1'b0) legal_count++;
            check_bit($sformatf("scan_rw_mw_%b", 7'(op)), reg_write & mem_write, 1'b0);
            check_bit($sformatf("scan_br_j_%b", 7'(op)), branch & jump, 1'b0);
        end
        checks++;
        assert (legal_count == 7) else begin
            errors++;
            $error("FAIL legal_count: observed %0d expected %0d", legal_count, 7);
        end

        // Back-to-back jal then lui
        step(7'b1101111);
        check("b2b_jal", c_ROW_JAL);
        step(7'b0110111);
        check("b2b_lui", c_ROW_LUI);
        step(7'b1100011);
        check("b2b_beq", c_ROW_BEQ);
        step(7'b0010011);
        check("b2b_itype", c_ROW_I);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
